// File: rtl/cpu16_ctrl_pkg.sv
// rtl/cpu16_ctrl_pkg.sv - shared states, opcodes and control encodings for the 16-bit datapath controller
package cpu16_ctrl_pkg;

    typedef enum logic [3:0] {
        START,
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_I,
        WB_I,
        MEM_ADDR,
        MEM_RD,
        WB_LD,
        MEM_WR,
        BRANCH,
        JUMP
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_SLT = 3'b100;

    // Codes consumed by the 16-bit ALU; keep in step with its decoder.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_BEQ = 4'b0111;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic func_valid(input logic [2:0] f);
        return f <= FN_SLT;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - maps controller state and R-type func to the ALU_Sel code
module alu_op_decode
    import cpu16_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [2:0]  func,
    output logic [3:0]  alu_sel
);

    always_comb begin
        alu_sel = ALU_ADD;
        case (state)
            EXEC_R: begin
                // Undefined func values fall through to add and are squashed at write-back.
                case (func)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            BRANCH:  alu_sel = ALU_BEQ;
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle fetch/decode/execute/memory/write-back control FSM
module multicycle_controller
    import cpu16_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [2:0]  func,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [3:0]  ALU_Sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_load,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic        retire
);

    state_t state_q;
    state_t state_d;

    alu_op_decode u_alu_op_decode (
        .state   (state_q),
        .func    (func),
        .alu_sel (ALU_Sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_load    = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PC_SRC_ALU;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            START: state_d = FETCH;

            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_ONE;
                pc_src    = PC_SRC_ALU;
                ir_write  = mem_ready;
                pc_load   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end

            DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R:    state_d = EXEC_R;
                    OP_ADDI: state_d = EXEC_I;
                    OP_LD:   state_d = MEM_ADDR;
                    OP_SW:   state_d = MEM_ADDR;
                    OP_BEQ:  state_d = BRANCH;
                    OP_J:    state_d = JUMP;
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end

            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                state_d   = WB_R;
            end

            WB_R: begin
                reg_dst   = 1'b1;
                reg_write = func_valid(func);
                retire    = 1'b1;
                state_d   = FETCH;
            end

            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = WB_I;
            end

            WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LD) ? MEM_RD : MEM_WR;
            end

            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = WB_LD;
            end

            WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end

            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
                if (mem_ready) state_d = FETCH;
            end

            BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                pc_src    = PC_SRC_ALUOUT;
                pc_load   = Zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            JUMP: begin
                pc_src  = PC_SRC_JUMP;
                pc_load = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end

            default: state_d = START;
        endcase
    end

endmodule
